// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and the divide-by-zero quotient fill.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DEFAULT_WIDTH = 8;

  // Replicated across the full quotient width on divide-by-zero.
  localparam logic DIV_DBZ_Q_BIT = 1'b1;

endpackage

// File: rtl/cla_subtractor_w.sv
// Parameterized W-bit carry-lookahead subtractor: diff = a + ~b + 1.
// borrow is high when a < b (no carry out of the top bit).
module cla_subtractor_w #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] bn;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  // Each carry is the flattened lookahead sum of generate terms plus the
  // all-propagate path from the implicit carry-in of 1.
  function automatic logic lookahead(input logic [W-1:0] gg, input logic [W-1:0] pp, input int n);
    logic acc;
    logic term;
    acc = 1'b1;
    for (int k = 0; k < n; k++) acc = acc & pp[k];
    for (int j = 0; j < n; j++) begin
      term = gg[j];
      for (int k = j + 1; k < n; k++) term = term & pp[k];
      acc = acc | term;
    end
    return acc;
  endfunction

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  assign c[0] = 1'b1;
  for (genvar i = 1; i <= W; i++) begin : g_carry
    assign c[i] = lookahead(g, p, i);
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement truncating division.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] op_dvd;
  logic [WIDTH-1:0] op_dvs;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic             unused_diff_msb;

  // The dividend shift register doubles as the quotient: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  assign shifted = {rem, qsr[WIDTH-1]};

  cla_subtractor_w #(.W(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvsr}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign rem_nx          = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_nx            = {qsr[WIDTH-2:0], ~borrow};
  assign unused_diff_msb = diff[WIDTH];

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Magnitudes are taken at accept; the most-negative value maps onto itself,
  // which as an unsigned magnitude is exactly right.
  assign op_dvd = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
  assign op_dvs = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
  assign res_q  = neg_q ? WIDTH'(-q_nx)   : q_nx;
  assign res_r  = neg_r ? WIDTH'(-rem_nx) : rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start && ready) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign op_dvd = dividend;
  assign op_dvs = divisor;
  assign res_q  = q_nx;
  assign res_r  = rem_nx;
`endif

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvsr        <= '0;
      qsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvsr        <= op_dvs;
            qsr         <= op_dvd;
            rem         <= '0;
            div_by_zero <= 1'b0;
            if (divisor != '0) begin
              state <= CALC;
              cnt   <= CNT_W'(WIDTH - 1);
              ready <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state       <= DONE;
              quotient    <= {WIDTH{DIV_DBZ_Q_BIT}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              ready       <= 1'b1;
              busy        <= 1'b0;
            end
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          rem <= rem_nx;
          qsr <= q_nx;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state     <= DONE;
            quotient  <= res_q;
            remainder <= res_r;
            done      <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus random
// operands against a plain-arithmetic reference model (honours DIV_SIGNED_EN).
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;
  int lat;
  int pulses;

  logic [W-1:0] eq;
  logic [W-1:0] er;
  logic         ez;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Truncating division from the language's own operators; zero divisor
  // yields the all-ones quotient and the untouched dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Drive a request and let it be accepted; returns #1 after the accept edge.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts samples from the accept edge until done, bounded at 20.
  task automatic wait_done();
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      check_output("busy_calc", busy, 1);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] b,
                              input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    check_output({tag, "_latency"}, lat, (b == '0) ? 1 : W + 1);
    check_output({tag, "_q"}, quotient, q);
    check_output({tag, "_r"}, remainder, r);
    check_output({tag, "_dbz"}, div_by_zero, z);
    check_output({tag, "_ready"}, ready, 1);
  endtask

  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    @(negedge clk);
    apply_stimulus(a, b);
    wait_done();
    check_result(tag, b, q, r, z);
    @(posedge clk);
    #1;
    check_output({tag, "_pulse"}, done, 0);
    check_output({tag, "_hold_q"}, quotient, q);
    check_output({tag, "_hold_r"}, remainder, r);
  endtask

  initial begin
    $display("[TB] seq_restoring_divider bench start");
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ready", ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_q", quotient, 0);
    check_output("rst_r", remainder, 0);
    check_output("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef DIV_SIGNED_EN
    do_div("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
    do_div("s_7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);
    do_div("s_ovf", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    do_div("s_dbz", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1);
`else
    do_div("u_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    do_div("u_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    do_div("u_3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0);
    do_div("u_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
`endif
    do_div("dbz_5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);

    // A start pulse mid-calculation must be ignored.
    ref_div(8'd200, 8'd7, eq, er, ez);
    @(negedge clk);
    apply_stimulus(8'd200, 8'd7);
    repeat (2) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 4;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_result("ign", 8'd7, eq, er, ez);

    // Back-to-back: new request issued in the DONE cycle.
    ref_div(8'd100, 8'd9, eq, er, ez);
    apply_stimulus(8'd100, 8'd9);
    wait_done();
    check_result("b2b", 8'd9, eq, er, ez);

    // Asynchronous reset partway through a calculation.
    @(negedge clk);
    apply_stimulus(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_ready", ready, 1);
    check_output("arst_busy", busy, 0);
    check_output("arst_q", quotient, 0);
    check_output("arst_r", remainder, 0);
    check_output("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check_output("arst_no_done", pulses, 0);
    do_div("post_rst", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      ref_div(a, b, eq, er, ez);
      do_div("rand", a, b, eq, er, ez);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
